configurable_smart_mac: RTL and testbench
=========================================

# configurable_smart_mac

Parametrised systolic-array processing element for the Mystique array. It generalises the single-mode smart MAC with a wide accumulator and a STAT_DEPTH-entry stationary-operand buffer. A run-length FSM supports output-stationary (OS) and weight/input-stationary (STAT) dataflows, with a valid/ready drain handshake for OS results. SSR bypass of the horizontal and vertical operand paths is retained so faulty or unused PEs can be skipped.

## Interface
- WORD_SIZE, 16, operand and vertical partial-sum width
- ACC_WIDTH, 40, OS accumulator width; must be >= 2*WORD_SIZE
- STAT_DEPTH, 4, stationary buffer entries (power of two, >= 2)
- K_WIDTH, 8, run-length counter width
- NUM_HOR_SSR, 2, horizontal SSR bits in (>= 2)
- NUM_VER_SSR, 2, vertical SSR bits in (>= 2)
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; asynchronous, active-high
- mode_in  in  1  0 = OS, 1 = STAT; sampled only on accepted start
- start_in  in  1  start a run (IDLE only)
- k_len_in  in  K_WIDTH  MAC beats in run; sampled with start
- valid_in  in  1  left_in/top_in carry a valid beat
- stat_wr_en_in / stat_wr_addr_in  in  1 / log2(STAT_DEPTH)  write top_in into buffer entry
- stat_sel_in  in  log2(STAT_DEPTH)  buffer entry used as STAT multiplicand
- hor_ssr_bits_in / ver_ssr_bits_in  in  NUM_HOR_SSR / NUM_VER_SSR  SSR chains
- hor_ssr_bits_out / ver_ssr_bits_out  out  NUM_HOR_SSR-1 / NUM_VER_SSR-1  bits[N-1:1] forwarded
- left_in / top_in  in  WORD_SIZE  operands
- right_out / bottom_out  out  WORD_SIZE  forwarded operand / partial sum
- acc_out  out  ACC_WIDTH  OS result
- acc_valid_out  out  1  acc_out valid (DRAIN)
- acc_ready_in  in  1  downstream accepts acc_out
- busy_out  out  1  state != IDLE

## Operation
- SSR: bit[0] of each chain is this PE's bypass bit; bits[N-1:1] forwarded unchanged.
- Registers: left_in_reg, top_in_reg, valid_reg capture every cycle.
- FSM states: IDLE, COMPUTE, DRAIN.
- IDLE + start_in: latch mode and k_len into cnt, clear accumulator.
  - k_len = 0: OS -> DRAIN; STAT -> IDLE.
  - otherwise -> COMPUTE.
- COMPUTE: each valid_reg beat is one MAC; cnt decrements. The beat taking cnt 1 -> 0 exits to DRAIN (OS) or IDLE (STAT).
- OS MAC: acc <= acc + left_in_reg*top_in_reg. Unsigned; product zero-extended to ACC_WIDTH; sum wraps mod 2^ACC_WIDTH.
- STAT MAC: psum_reg <= (left_in_reg*stat_buf[stat_sel_in] + top_in_reg)[WORD_SIZE-1:0].
- DRAIN: acc_valid_out=1, acc_out=acc. acc_valid_out && acc_ready_in -> IDLE, acc cleared. Hold acc_out while ready is low.
- Buffer write: allowed in any state; same-cycle write and read of the same entry returns the old value.
- right_out = hor bypass ? left_in : left_in_reg.
- bottom_out = ver bypass ? top_in : (STAT mode latched ? psum_reg : top_in_reg).
- start_in outside IDLE is ignored. valid_in outside COMPUTE updates registers but does not MAC.

## Timing
- Reset values: all registers 0, state IDLE. right_out/bottom_out = 0 unless bypass is set (then combinational passthrough); acc_out 0; acc_valid_out 0; busy_out 0; buffer cleared.
- Operand latency is 1 cycle to right_out/bottom_out; bypass latency is 0.
- STAT psum appears on bottom_out 2 cycles after its operands present at the ports.
- OS: acc_valid_out rises the cycle after the final valid beat is registered (plus the MAC edge). For k_len = 0 it rises the cycle after start.
- Handshake completes on the edge where valid && ready; busy_out falls the following cycle. Back-to-back start is accepted in that next cycle.
- rst mid-run aborts immediately to IDLE; partial accumulation is discarded.

## Configuration
- CONFIGURABLE_SMART_MAC_SATURATE_EN
  - Defined: OS accumulation saturates to 2^ACC_WIDTH-1 and the STAT psum saturates to 2^WORD_SIZE-1.
  - Undefined: both wrap modulo width.

## Test plan
- OS, k_len=3, beats (2,3),(4,5),(6,7), ready=1 -> acc_out=68 for one cycle with acc_valid_out=1, then busy_out=0.
- OS, k_len=2, ready held low 5 cycles -> acc_valid_out and acc_out stay stable; accept on first ready cycle; start_in pulsed in DRAIN is ignored.
- STAT: write 3 to entry 2, stat_sel=2, left=5, top=10 -> bottom_out=25 two cycles later. Write and read entry 2 in the same cycle -> old value used.
- Overflow, WORD_SIZE=16, ACC_WIDTH=32: 0xFFFF*0xFFFF twice -> wrapped 0xFFFC0002 without macro; 0xFFFFFFFF with the macro. STAT 0xFFFF*2+1 -> 0xFFFF saturated / 0xFFFF wrapped.
- SSR: hor_ssr_bits_in=2'b01 -> right_out==left_in same cycle, hor_ssr_bits_out=1'b0. ver_ssr_bits_in=2'b10 -> bottom_out registered, ver_ssr_bits_out=1'b1.
- rst asserted mid-COMPUTE (cnt=2) -> all outputs 0 asynchronously; a new start with k_len=1 gives a result from a clean accumulator.

Source files
------------

// File: rtl/configurable_smart_mac.sv
// Mystique systolic PE: output-stationary accumulate / stationary multiply-add with SSR bypass.
// Define CONFIGURABLE_SMART_MAC_SATURATE_EN to saturate the accumulator and psum instead of wrapping.
module configurable_smart_mac #(
    parameter int WORD_SIZE   = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int STAT_DEPTH  = 4,
    parameter int K_WIDTH     = 8,
    parameter int NUM_HOR_SSR = 2,
    parameter int NUM_VER_SSR = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode_in,
    input  logic                          start_in,
    input  logic [K_WIDTH-1:0]            k_len_in,
    input  logic                          valid_in,
    input  logic                          stat_wr_en_in,
    input  logic [$clog2(STAT_DEPTH)-1:0] stat_wr_addr_in,
    input  logic [$clog2(STAT_DEPTH)-1:0] stat_sel_in,
    input  logic [NUM_HOR_SSR-1:0]        hor_ssr_bits_in,
    input  logic [NUM_VER_SSR-1:0]        ver_ssr_bits_in,
    output logic [NUM_HOR_SSR-2:0]        hor_ssr_bits_out,
    output logic [NUM_VER_SSR-2:0]        ver_ssr_bits_out,
    input  logic [WORD_SIZE-1:0]          left_in,
    input  logic [WORD_SIZE-1:0]          top_in,
    output logic [WORD_SIZE-1:0]          right_out,
    output logic [WORD_SIZE-1:0]          bottom_out,
    output logic [ACC_WIDTH-1:0]          acc_out,
    output logic                          acc_valid_out,
    input  logic                          acc_ready_in,
    output logic                          busy_out
);

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [K_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_next;
    logic [WORD_SIZE-1:0] psum_q, psum_d, psum_next;
    logic [WORD_SIZE-1:0] left_q, top_q;
    logic                 valid_q;
    logic [WORD_SIZE-1:0] stat_buf_q [STAT_DEPTH];

    logic [2*WORD_SIZE-1:0] os_prod;
    logic [WORD_SIZE-1:0]   stat_op;

    assign os_prod = {{WORD_SIZE{1'b0}}, left_q} * {{WORD_SIZE{1'b0}}, top_q};
    // Buffer is read before this cycle's write lands, so a same-entry write/read sees the old value.
    assign stat_op = stat_buf_q[stat_sel_in];

`ifdef CONFIGURABLE_SMART_MAC_SATURATE_EN
    logic [ACC_WIDTH:0]   acc_sum;
    logic [2*WORD_SIZE:0] psum_full;

    always_comb begin
        acc_sum = '0;
        acc_sum[2*WORD_SIZE-1:0] = os_prod;
        acc_sum = acc_sum + {1'b0, acc_q};
        acc_next = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
        psum_full = {1'b0, {WORD_SIZE{1'b0}}, left_q} * {1'b0, {WORD_SIZE{1'b0}}, stat_op};
        psum_full = psum_full + {{(WORD_SIZE+1){1'b0}}, top_q};
        psum_next = (|psum_full[2*WORD_SIZE:WORD_SIZE]) ? '1 : psum_full[WORD_SIZE-1:0];
    end
`else
    always_comb begin
        acc_next = '0;
        acc_next[2*WORD_SIZE-1:0] = os_prod;
        acc_next = acc_next + acc_q;
        psum_next = left_q * stat_op + top_q;
    end
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d       = state_q;
        mode_d        = mode_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        psum_d        = psum_q;
        acc_valid_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    mode_d = mode_in;
                    cnt_d  = k_len_in;
                    acc_d  = '0;
                    if (k_len_in == '0) state_d = mode_in ? IDLE : DRAIN;
                    else                state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (valid_q) begin
                    cnt_d = cnt_q - K_WIDTH'(1);
                    if (mode_q) psum_d = psum_next;
                    else        acc_d  = acc_next;
                    if (cnt_q == K_WIDTH'(1)) state_d = mode_q ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                acc_valid_out = 1'b1;
                if (acc_ready_in) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            psum_q  <= '0;
            left_q  <= '0;
            top_q   <= '0;
            valid_q <= 1'b0;
            // NOTE: the stationary buffer is a small register file that must read zero after reset, so it is reset like any other state.
            for (int i = 0; i < STAT_DEPTH; i++) stat_buf_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            psum_q  <= psum_d;
            left_q  <= left_in;
            top_q   <= top_in;
            valid_q <= valid_in;
            if (stat_wr_en_in) stat_buf_q[stat_wr_addr_in] <= top_in;
        end
    end

    assign hor_ssr_bits_out = hor_ssr_bits_in[NUM_HOR_SSR-1:1];
    assign ver_ssr_bits_out = ver_ssr_bits_in[NUM_VER_SSR-1:1];
    assign right_out        = hor_ssr_bits_in[0] ? left_in : left_q;
    assign bottom_out       = ver_ssr_bits_in[0] ? top_in : (mode_q ? psum_q : top_q);
    assign acc_out          = acc_q;
    assign busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_configurable_smart_mac.sv
// Scoreboard bench for configurable_smart_mac: OS results checked on handshake, STAT psums on their due cycle.
// Builds with or without CONFIGURABLE_SMART_MAC_SATURATE_EN; the reference model follows the same define.
module tb_configurable_smart_mac;
    localparam int W  = 16;
    localparam int AW = 32;
    localparam int SD = 4;
    localparam int KW = 8;
    localparam longint unsigned ACC_MAX = (64'd1 << AW) - 1;
    localparam longint unsigned WORD_MAX = (64'd1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode_in = 1'b0, start_in = 1'b0, valid_in = 1'b0;
    logic [KW-1:0] k_len_in = '0;
    logic          stat_wr_en_in = 1'b0;
    logic [1:0]    stat_wr_addr_in = '0, stat_sel_in = '0;
    logic [1:0]    hor_ssr_bits_in = '0, ver_ssr_bits_in = '0;
    logic [0:0]    hor_ssr_bits_out, ver_ssr_bits_out;
    logic [W-1:0]  left_in = '0, top_in = '0, right_out, bottom_out;
    logic [AW-1:0] acc_out;
    logic          acc_valid_out, acc_ready_in = 1'b1, busy_out;

    configurable_smart_mac #(
        .WORD_SIZE(W), .ACC_WIDTH(AW), .STAT_DEPTH(SD), .K_WIDTH(KW),
        .NUM_HOR_SSR(2), .NUM_VER_SSR(2)
    ) dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .start_in(start_in), .k_len_in(k_len_in),
        .valid_in(valid_in), .stat_wr_en_in(stat_wr_en_in), .stat_wr_addr_in(stat_wr_addr_in),
        .stat_sel_in(stat_sel_in), .hor_ssr_bits_in(hor_ssr_bits_in), .ver_ssr_bits_in(ver_ssr_bits_in),
        .hor_ssr_bits_out(hor_ssr_bits_out), .ver_ssr_bits_out(ver_ssr_bits_out),
        .left_in(left_in), .top_in(top_in), .right_out(right_out), .bottom_out(bottom_out),
        .acc_out(acc_out), .acc_valid_out(acc_valid_out), .acc_ready_in(acc_ready_in), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           due;
        logic [W-1:0] val;
    } stat_exp_t;

    logic [AW-1:0] os_q[$];
    stat_exp_t     stat_q[$];
    stat_exp_t     s_head;
    logic [W-1:0]  buf_m [SD];

    // Per-run stimulus tables filled before calling run_os / run_stat.
    logic [W-1:0]  va [8];
    logic [W-1:0]  vb [8];
    logic [1:0]    vsel [8];
    logic          vwen [8];
    logic [1:0]    vwaddr [8];
    logic [W-1:0]  vwdata [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] os_step(input logic [AW-1:0] acc, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned s;
        s = longint'(acc) + longint'(a) * longint'(b);
`ifdef CONFIGURABLE_SMART_MAC_SATURATE_EN
        if (s > ACC_MAX) s = ACC_MAX;
`else
        s = s & ACC_MAX;
`endif
        return s[AW-1:0];
    endfunction

    function automatic logic [W-1:0] stat_val(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        longint unsigned s;
        s = longint'(a) * longint'(b) + longint'(c);
`ifdef CONFIGURABLE_SMART_MAC_SATURATE_EN
        if (s > WORD_MAX) s = WORD_MAX;
`else
        s = s & WORD_MAX;
`endif
        return s[W-1:0];
    endfunction

    // Monitor: OS results leave on the handshake, STAT psums are due on a known cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (acc_valid_out && acc_ready_in) begin
                if (os_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL os_unexpected: got 0x%0h with no result expected", acc_out);
                end else begin
                    check("os_result", acc_out, os_q.pop_front());
                end
            end
            while (stat_q.size() > 0 && stat_q[0].due <= cyc) begin
                s_head = stat_q.pop_front();
                if (s_head.due == cyc) begin
                    check("stat_psum", bottom_out, s_head.val);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL stat_missed: due cycle %0d, now %0d", s_head.due, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_out && n < 100) begin
            tick();
            n++;
        end
        check(name, busy_out, 0);
    endtask

    task automatic write_buf(input logic [1:0] addr, input logic [W-1:0] data);
        stat_wr_en_in   = 1'b1;
        stat_wr_addr_in = addr;
        top_in          = data;
        tick();
        stat_wr_en_in   = 1'b0;
        buf_m[addr]     = data;
    endtask

    task automatic run_os(input int k, input int gap_max, input int ready_delay);
        logic [AW-1:0] exp_acc = '0;
        acc_ready_in = (ready_delay == 0);
        mode_in  = 1'b0;
        k_len_in = KW'(k);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        if (k == 0) begin
            os_q.push_back('0);
        end else begin
            for (int i = 0; i < k; i++) begin
                left_in  = va[i];
                top_in   = vb[i];
                valid_in = 1'b1;
                exp_acc  = os_step(exp_acc, va[i], vb[i]);
                if (i == k - 1) os_q.push_back(exp_acc);
                tick();
                valid_in = 1'b0;
                if (i < k - 1) repeat ($urandom_range(gap_max, 0)) tick();
            end
            check("os_valid_early", acc_valid_out, 0);
            tick();
        end
        check("os_valid_rise", acc_valid_out, 1);
        for (int d = 0; d < ready_delay; d++) begin
            check("os_hold_valid", acc_valid_out, 1);
            check("os_hold_value", acc_out, exp_acc);
            if (d == 2) begin
                start_in = 1'b1;
                mode_in  = 1'b1;
                k_len_in = '0;
            end
            tick();
            start_in = 1'b0;
        end
        acc_ready_in = 1'b1;
        wait_idle("os_busy_fall");
        check("os_valid_drop", acc_valid_out, 0);
        check("os_acc_cleared", acc_out, 0);
    endtask

    task automatic run_stat(input int k);
        mode_in  = 1'b1;
        k_len_in = KW'(k);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < k; i++) begin
            left_in     = va[i];
            top_in      = vb[i];
            stat_sel_in = vsel[i];
            valid_in    = 1'b1;
            tick();
            valid_in = 1'b0;
            stat_q.push_back('{due: cyc + 1, val: stat_val(va[i], buf_m[vsel[i]], vb[i])});
            if (vwen[i]) begin
                stat_wr_en_in   = 1'b1;
                stat_wr_addr_in = vwaddr[i];
                top_in          = vwdata[i];
                buf_m[vwaddr[i]] = vwdata[i];
            end
            tick();
            stat_wr_en_in = 1'b0;
        end
        check("stat_done_idle", busy_out, 0);
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 8; i++) begin
            va[i] = '0; vb[i] = '0; vsel[i] = '0;
            vwen[i] = 1'b0; vwaddr[i] = '0; vwdata[i] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < SD; i++) buf_m[i] = '0;
        clear_tables();
        tick();
        tick();
        check("rst_acc_out", acc_out, 0);
        check("rst_acc_valid", acc_valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_right", right_out, 0);
        check("rst_bottom", bottom_out, 0);
        rst = 1'b0;
        tick();

        // SSR bypass and registered paths
        hor_ssr_bits_in = 2'b01;
        ver_ssr_bits_in = 2'b10;
        left_in = 16'hABCD;
        top_in  = 16'h1234;
        #1;
        check("hor_bypass", right_out, 16'hABCD);
        check("hor_ssr_out", hor_ssr_bits_out, 0);
        check("ver_ssr_out", ver_ssr_bits_out, 1);
        check("ver_reg_before", bottom_out, 0);
        tick();
        check("ver_reg_after", bottom_out, 16'h1234);
        hor_ssr_bits_in = 2'b10;
        ver_ssr_bits_in = 2'b01;
        left_in = 16'h0F0F;
        top_in  = 16'h5555;
        #1;
        check("hor_reg", right_out, 16'hABCD);
        check("hor_ssr_out_hi", hor_ssr_bits_out, 1);
        check("ver_bypass", bottom_out, 16'h5555);
        hor_ssr_bits_in = 2'b00;
        ver_ssr_bits_in = 2'b00;
        tick();

        // OS directed: 2*3 + 4*5 + 6*7 = 68
        clear_tables();
        va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 6; vb[2] = 7;
        run_os(3, 0, 0);
        // OS with ready held low and an ignored start in DRAIN
        va[0] = 16'h0123; vb[0] = 16'h0456; va[1] = 16'h0789; vb[1] = 16'h0ABC;
        run_os(2, 1, 5);
        // OS k_len = 0
        run_os(0, 0, 1);
        // OS overflow: 0xFFFF*0xFFFF twice
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; va[1] = 16'hFFFF; vb[1] = 16'hFFFF;
        run_os(2, 0, 0);
        // OS random
        for (int r = 0; r < 6; r++) begin
            int k = $urandom_range(6, 1);
            for (int i = 0; i < k; i++) begin
                va[i] = W'($urandom);
                vb[i] = W'($urandom);
            end
            run_os(k, 2, $urandom_range(3, 0));
        end

        // STAT directed: 5*3+10 = 25, then same-cycle write of entry 2 still uses 3
        clear_tables();
        write_buf(2'd2, 16'd3);
        va[0] = 5; vb[0] = 10; vsel[0] = 2;
        va[1] = 4; vb[1] = 1;  vsel[1] = 2; vwen[1] = 1'b1; vwaddr[1] = 2; vwdata[1] = 16'd9;
        run_stat(2);
        clear_tables();
        va[0] = 1; vb[0] = 0; vsel[0] = 2;
        run_stat(1);
        // STAT k_len = 0 returns straight to IDLE
        run_stat(0);
        // STAT overflow: 0xFFFF*2+1
        write_buf(2'd1, 16'd2);
        va[0] = 16'hFFFF; vb[0] = 16'd1; vsel[0] = 1;
        run_stat(1);
        // STAT random
        for (int r = 0; r < 6; r++) begin
            int k = $urandom_range(4, 1);
            clear_tables();
            for (int i = 0; i < k; i++) begin
                va[i] = W'($urandom); vb[i] = W'($urandom); vsel[i] = 2'($urandom);
                vwen[i] = 1'($urandom); vwaddr[i] = 2'($urandom); vwdata[i] = W'($urandom);
            end
            run_stat(k);
        end

        // Reset mid-COMPUTE after one MAC (cnt = 2)
        mode_in  = 1'b0;
        k_len_in = 8'd3;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        left_in  = 2;
        top_in   = 3;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        check("abort_partial", acc_out, 6);
        #2 rst = 1'b1;
        #1;
        check("abort_acc", acc_out, 0);
        check("abort_busy", busy_out, 0);
        check("abort_valid", acc_valid_out, 0);
        check("abort_right", right_out, 0);
        check("abort_bottom", bottom_out, 0);
        for (int i = 0; i < SD; i++) buf_m[i] = '0;
        tick();
        rst = 1'b0;
        tick();
        clear_tables();
        va[0] = 3; vb[0] = 4;
        run_os(1, 0, 0);
        // Buffer cleared by reset: 7*0 + 5
        va[0] = 7; vb[0] = 5; vsel[0] = 2;
        run_stat(1);

        tick();
        tick();
        check("os_queue_drained", os_q.size(), 0);
        check("stat_queue_drained", stat_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
